encoder_4x2_seq: RTL and testbench

Registered 4-to-2 priority encoder with a request-pending latch and a valid/ready output handshake. It is the inverse of the lab 2x4 decoder: up to four request lines are collected into a pending register and returned one at a time as a 2-bit code. It sits between request sources, such as interrupt or button lines, and a consumer that accepts one encoded index per handshake.

---
 rtl/encoder_4x2_seq.sv | 119 +++++++++++
 tb/tb_encoder_4x2_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_4x2_seq.sv
// rtl/encoder_4x2_seq.sv - registered 4-to-2 priority encoder with pending latch and valid/ready output
// Optional build macro ROUND_ROBIN_EN selects rotating priority instead of fixed bit-3-highest priority.
module encoder_4x2_seq #(
    parameter int N_IN   = 4,
    parameter int CODE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_IN-1:0]   req,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              out_valid,
    output logic [N_IN-1:0]   pending,
    output logic              ovf
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     pending_q, pending_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic                sel_found;
    logic [CODE_W-1:0]   sel_idx;
    logic                grant;
    logic [N_IN-1:0]     clr;
    logic [N_IN-1:0]     set;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0]   ptr_q, ptr_d;

    // Search starts one past the last grant; the final iteration wraps back onto the pointer itself.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= N_IN; i++) begin
            if (!sel_found && pending_q[ptr_q + CODE_W'(i)]) begin
                sel_found = 1'b1;
                sel_idx   = ptr_q + CODE_W'(i);
            end
        end
    end

    always_comb begin
        ptr_d = grant ? sel_idx : ptr_q;
    end
`else
    always_comb begin
        sel_found = |pending_q;
        sel_idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (pending_q[i]) begin
                sel_idx = CODE_W'(i);
            end
        end
    end
`endif

    // The granted bit already left pending when code loaded, so pending_q alone decides back-to-back grants.
    assign grant = sel_found && ((state_q == IDLE) || out_ready);
    assign clr   = grant ? (N_IN'(1) << sel_idx) : '0;
    assign set   = en ? req : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
`ifdef ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !sel_found) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set wins over a same-cycle clear; overflow ignores the bit being granted this cycle.
    always_comb begin
        pending_d = (pending_q & ~clr) | set;
        ovf_d     = ovf_q | (|(set & pending_q & ~clr));
        code_d    = grant ? sel_idx : code_q;
        valid_d   = (state_d == HOLD);
    end

    assign code      = code_q;
    assign out_valid = valid_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// tb/tb_encoder_4x2_seq.sv - scoreboard testbench for encoder_4x2_seq
module tb_encoder_4x2_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] code;
    logic       out_valid;
    logic [3:0] pending;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];

    encoder_4x2_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .out_ready (out_ready),
        .code      (code),
        .out_valid (out_valid),
        .pending   (pending),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake seen at the falling edge must match the next queued code.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL handshake_unexpected: got code %0d with empty scoreboard at %0t", code, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (code !== e) begin
                    n_bad++;
                    $display("FAIL handshake_code: got %0d expected %0d at %0t", code, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; req = 4'b0000; out_ready = 1'b1;
        #2;
        check("reset_valid", {3'b0, out_valid}, 4'h0);
        check("reset_code", {2'b0, code}, 4'h0);
        check("reset_pending", pending, 4'h0);
        check("reset_ovf", {3'b0, ovf}, 4'h0);
        step();
        rst_n = 1'b1;
        step();

        // Single request: valid for exactly one cycle, two edges after req.
        exp_q.push_back(2'd2);
        req = 4'b0100;
        step();
        req = 4'b0000;
        check("single_pending", pending, 4'b0100);
        check("single_notyet", {3'b0, out_valid}, 4'h0);
        step();
        check("single_valid", {3'b0, out_valid}, 4'h1);
        check("single_code", {2'b0, code}, 4'h2);
        check("single_drained", pending, 4'h0);
        step();
        check("single_onecycle", {3'b0, out_valid}, 4'h0);

        // Multi-hot fixed priority: 11, 01, 00 back to back.
        exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        req = 4'b1011;
        step();
        req = 4'b0000;
        step();
        check("multi_first", {2'b0, code}, 4'h3);
        step();
        check("multi_second", {2'b0, code}, 4'h1);
        step();
        check("multi_third", {2'b0, code}, 4'h0);
        check("multi_third_valid", {3'b0, out_valid}, 4'h1);
        step();
        check("multi_idle", {3'b0, out_valid}, 4'h0);

        // Backpressure and overflow.
        out_ready = 1'b0;
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        step();
        step();
        check("bp_hold_valid", {3'b0, out_valid}, 4'h1);
        check("bp_hold_code", {2'b0, code}, 4'h0);
        req = 4'b0011;
        step();
        check("bp_pending", pending, 4'b0011);
        check("bp_no_ovf", {3'b0, ovf}, 4'h0);
        step();
        req = 4'b0000;
        check("bp_ovf_set", {3'b0, ovf}, 4'h1);
        step();
        check("bp_ovf_sticky", {3'b0, ovf}, 4'h1);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        out_ready = 1'b1;
        step(); step(); step(); step();
        check("bp_drain_valid", {3'b0, out_valid}, 4'h0);
        check("bp_drain_pending", pending, 4'h0);
        check("bp_ovf_still", {3'b0, ovf}, 4'h1);

        // Enable masking.
        en = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_mask_pending", pending, 4'h0);
            check("en_mask_valid", {3'b0, out_valid}, 4'h0);
        end
        en = 1'b1;
        req = 4'b0010;
        exp_q.push_back(2'd1);
        step();
        req = 4'b0000;
        step();
        check("en_code", {2'b0, code}, 4'h1);
        check("en_valid", {3'b0, out_valid}, 4'h1);
        step();

        // Asynchronous reset in HOLD with pending 0110.
        out_ready = 1'b0;
        req = 4'b1110;
        step();
        req = 4'b0000;
        step();
        check("rst_pre_pending", pending, 4'b0110);
        check("rst_pre_code", {2'b0, code}, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", {3'b0, out_valid}, 4'h0);
        check("rst_pending", pending, 4'h0);
        check("rst_code", {2'b0, code}, 4'h0);
        check("rst_ovf", {3'b0, ovf}, 4'h0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Held req 1001 for four edges, then released.
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
`else
        exp_q.push_back(2'd3); exp_q.push_back(2'd3); exp_q.push_back(2'd3);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
`endif
        req = 4'b1001;
        step(); step(); step(); step();
        req = 4'b0000;
        step(); step(); step(); step();
        check("hold_final_valid", {3'b0, out_valid}, 4'h0);
        check("hold_final_pending", pending, 4'h0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: %0d codes never presented, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
